led_trail_pwm: RTL and testbench



---
 rtl/led_pkg.sv | 19 +
 rtl/led_pwm_channel.sv | 45 ++++
 rtl/led_trail_pwm.sv | 69 ++++++
 tb/tb_led_trail_pwm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared helpers for the LED comet-tail PWM stage: brightness ceiling and parameter legality.
package led_pkg;

    function automatic int unsigned level_max(input int unsigned pwm_bits);
        return (32'd1 << pwm_bits) - 32'd1;
    endfunction

    // True when the parameter set yields a well-formed timer and decay step.
    function automatic bit params_ok(
        input int unsigned pwm_bits,
        input int unsigned decay_div,
        input int unsigned decay_step
    );
        return (pwm_bits >= 32'd1) && (pwm_bits <= 32'd16) &&
               (decay_div >= 32'd2) &&
               (decay_step >= 32'd1) && (decay_step <= level_max(pwm_bits));
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with load/saturating decay, and a PWM comparator.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned DECAY_STEP = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic                i_decay_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q, led_d;

    // Load has priority over decay; decay floors at zero instead of wrapping.
    always_comb begin
        level_d = level_q;
        led_d   = (level_q > i_pwm_cnt);
        if (i_load) begin
            level_d = LVL_MAX;
        end else if (i_decay_tick) begin
            level_d = (level_q <= STEP) ? '0 : (level_q - STEP);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: lit pattern bits snap to full brightness and fade in fixed steps.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned DECAY_DIV  = 1024,
    parameter int unsigned DECAY_STEP = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_led,
    output logic [WIDTH-1:0] o_led,
    output logic             o_pwm_sync
);

    localparam int unsigned       DCNT_W    = (DECAY_DIV > 32'd1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 32'd1);

    if (!params_ok(PWM_BITS, DECAY_DIV, DECAY_STEP)) begin : g_param_err
        $error("led_trail_pwm: illegal PWM_BITS/DECAY_DIV/DECAY_STEP combination");
    end

    logic [WIDTH-1:0]    i_led_q, i_led_d;
    logic [DCNT_W-1:0]   decay_cnt_q, decay_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_sync_q, pwm_sync_d;
    logic                decay_tick_c;

    // Shared timers; sync is computed from the same pwm_cnt the channels compare against.
    always_comb begin
        i_led_d      = i_led;
        decay_tick_c = (decay_cnt_q == DCNT_LAST);
        decay_cnt_d  = decay_tick_c ? '0 : (decay_cnt_q + DCNT_W'(1));
        pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(1);
        pwm_sync_d   = (pwm_cnt_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            i_led_q     <= '0;
            decay_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            pwm_sync_q  <= 1'b0;
        end else begin
            i_led_q     <= i_led_d;
            decay_cnt_q <= decay_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_sync_q  <= pwm_sync_d;
        end
    end

    for (genvar k = 0; k < int'(WIDTH); k++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_load       (i_led_q[k]),
            .i_decay_tick (decay_tick_c),
            .i_pwm_cnt    (pwm_cnt_q),
            .o_led        (o_led[k])
        );
    end

    assign o_pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: small-parameter directed scenarios plus a default-parameter random run.
module tb_led_trail_pwm;

    localparam int S_W = 4, S_PB = 4, S_DIV = 4, S_STEP = 4, S_MAX = 15;
    localparam int D_W = 8, D_PB = 8, D_DIV = 1024, D_STEP = 32, D_MAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_s, rst_d;
    logic [S_W-1:0]   led_s, out_s;
    logic [D_W-1:0]   led_d, out_d;
    logic             sync_s, sync_d;

    led_trail_pwm #(.WIDTH(S_W), .PWM_BITS(S_PB), .DECAY_DIV(S_DIV), .DECAY_STEP(S_STEP)) dut_s (
        .i_clk(clk), .i_reset(rst_s), .i_led(led_s), .o_led(out_s), .o_pwm_sync(sync_s)
    );

    led_trail_pwm dut_d (
        .i_clk(clk), .i_reset(rst_d), .i_led(led_d), .o_led(out_d), .o_pwm_sync(sync_d)
    );

    int checks = 0;
    int failures = 0;

    logic [S_W:0] q_s[$];
    logic [D_W:0] q_d[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, small instance: integer brightness per LED, pushes the value
    // the outputs must show after this edge.
    int             lvl_s[S_W];
    int             dcnt_s, pcnt_s;
    logic [S_W-1:0] iq_s, e_s;
    bit             es_s;
    initial begin
        forever begin
            @(posedge clk);
            if (rst_s) begin
                e_s = '0; es_s = 1'b0;
                for (int k = 0; k < S_W; k++) lvl_s[k] = 0;
                dcnt_s = 0; pcnt_s = 0; iq_s = '0;
            end else begin
                for (int k = 0; k < S_W; k++) e_s[k] = (lvl_s[k] > pcnt_s);
                es_s = (pcnt_s == 0);
                for (int k = 0; k < S_W; k++) begin
                    if (iq_s[k]) lvl_s[k] = S_MAX;
                    else if (dcnt_s == S_DIV - 1) lvl_s[k] = (lvl_s[k] > S_STEP) ? lvl_s[k] - S_STEP : 0;
                end
                dcnt_s = (dcnt_s + 1) % S_DIV;
                pcnt_s = (pcnt_s + 1) % (S_MAX + 1);
                iq_s   = led_s;
            end
            q_s.push_back({e_s, es_s});
        end
    end

    // Reference model, default-parameter instance.
    int             lvl_d[D_W];
    int             dcnt_d, pcnt_d;
    logic [D_W-1:0] iq_d, e_d;
    bit             es_d;
    initial begin
        forever begin
            @(posedge clk);
            if (rst_d) begin
                e_d = '0; es_d = 1'b0;
                for (int k = 0; k < D_W; k++) lvl_d[k] = 0;
                dcnt_d = 0; pcnt_d = 0; iq_d = '0;
            end else begin
                for (int k = 0; k < D_W; k++) e_d[k] = (lvl_d[k] > pcnt_d);
                es_d = (pcnt_d == 0);
                for (int k = 0; k < D_W; k++) begin
                    if (iq_d[k]) lvl_d[k] = D_MAX;
                    else if (dcnt_d == D_DIV - 1) lvl_d[k] = (lvl_d[k] > D_STEP) ? lvl_d[k] - D_STEP : 0;
                end
                dcnt_d = (dcnt_d + 1) % D_DIV;
                pcnt_d = (pcnt_d + 1) % (D_MAX + 1);
                iq_d   = led_d;
            end
            q_d.push_back({e_d, es_d});
        end
    end

    // Monitor: pops expected outputs and compares on the falling edge.
    logic [S_W:0] exp_sv;
    logic [D_W:0] exp_dv;
    initial begin
        forever begin
            @(negedge clk);
            if (q_s.size() > 0) begin
                exp_sv = q_s.pop_front();
                check("sb_small", int'({out_s, sync_s}), int'(exp_sv));
            end
            if (q_d.size() > 0) begin
                exp_dv = q_d.pop_front();
                check("sb_dflt", int'({out_d, sync_d}), int'(exp_dv));
            end
        end
    end

    task automatic count_win(input int cycles, output int c0, output int c1, output int c23);
        c0 = 0; c1 = 0; c23 = 0;
        repeat (cycles) begin
            @(negedge clk);
            c0  += int'(out_s[0]);
            c1  += int'(out_s[1]);
            c23 += int'(out_s[2]) + int'(out_s[3]);
        end
    endtask

    task automatic restart_small();
        rst_s = 1'b1; led_s = '0;
        @(negedge clk);
        rst_s = 1'b0;
    endtask

    // Pulse LED0 for one cycle so it is sampled at the 14th edge after reset release.
    task automatic fade_pulse();
        restart_small();
        repeat (13) @(negedge clk);
        led_s = 4'b0001;
        @(negedge clk);
        led_s = '0;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    int n, c0, c1, c23;
    logic [S_W-1:0] walk[7];

    initial begin
        rst_s = 1'b1; rst_d = 1'b1;
        led_s = 4'hF; led_d = '0;
        repeat (3) @(negedge clk);
        check("rst_led", int'(out_s), 0);
        check("rst_sync", int'(sync_s), 0);

        rst_s = 1'b0; led_s = '0;
        @(negedge clk);
        check("sync_first", int'(sync_s), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync_s && n < 40);
        check("sync_period", n, 16);

        led_s = 4'b0001;
        repeat (4) @(negedge clk);
        count_win(16, c0, c1, c23);
        check("static_duty", c0, 15);
        check("static_others", c1 + c23, 0);

        led_s = 4'b0010;
        repeat (4) @(negedge clk);
        count_win(48, c0, c1, c23);
        check("load_beats_decay", c1, 45);
        led_s = '0;
        repeat (40) @(negedge clk);

        // Levels 11,7,3 land on pwm phases 0-3, 4-7, 8-11 respectively.
        fade_pulse();
        count_win(80, c0, c1, c23);
        check("fade_on", c0, 7);
        check("fade_others", c1 + c23, 0);

        fade_pulse();
        repeat (7) @(negedge clk);
        check("midfade_pre", int'(out_s[0]), 1);
        rst_s = 1'b1;
        @(negedge clk);
        check("midfade_rst", int'(out_s), 0);
        rst_s = 1'b0;
        count_win(64, c0, c1, c23);
        check("midfade_dark", c0 + c1 + c23, 0);

        walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        foreach (walk[i]) begin
            led_s = walk[i];
            repeat (8) @(negedge clk);
        end
        led_s = '0;
        repeat (48) @(negedge clk);
        check("walk_dark", int'(out_s), 0);

        rst_d = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (i == 6000) rst_d = 1'b1;
            if (i == 6001) rst_d = 1'b0;
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0:       led_d = '0;
                    3:       led_d = 8'($urandom);
                    default: led_d = 8'd1 << $urandom_range(0, 7);
                endcase
            end
            @(negedge clk);
        end
        led_d = '0;
        repeat (9000) @(negedge clk);
        check("dflt_dark", int'(out_d), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
